// File: rtl/apu_dma_pkg.sv
// Shared definitions for the DMC sample-fetch DMA responder:
// FSM state encoding, bus widths and a small state-decode helper.
package apu_dma_pkg;

   localparam int DMA_ADDR_W = 16;
   localparam int DMA_DATA_W = 8;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_HALT  = 3'd1,
      S_STALL = 3'd2,
      S_READ  = 3'd3,
      S_ACK   = 3'd4
   } dma_state_t;

   // The CPU is held off the bus from the halt request until the read completes.
   function automatic logic owns_bus(input dma_state_t s);
      return (s == S_HALT) || (s == S_STALL) || (s == S_READ);
   endfunction

endpackage

// File: rtl/apu_dmc_dma_responder.sv
// Bus-side responder for DMC sample-fetch DMA requests.
// Halts the CPU at a read cycle, inserts STALL_CYCLES dummy cycles, performs
// one byte read and returns it with a one-cycle acknowledge.
// Optional statistics outputs (halt-cycle and abort counters) are built when
// the macro APU_DMC_DMA_STATS_EN is defined.
module apu_dmc_dma_responder
   import apu_dma_pkg::*;
#(
   parameter int STALL_CYCLES = 3,
   parameter int STALL_W      = 2
) (
   input  logic                  iClk,
   input  logic                  iReset,
   input  logic                  iDMA_req,
   input  logic [DMA_ADDR_W-1:0] iDMA_addr,
   output logic                  oDMA_ack,
   output logic [DMA_DATA_W-1:0] oDMA_data,
   output logic                  oCPU_halt,
   input  logic                  iCPU_rdy,
   output logic                  oMem_rd,
   output logic [DMA_ADDR_W-1:0] oMem_addr,
   input  logic [DMA_DATA_W-1:0] iMem_data,
   input  logic                  iMem_valid
`ifdef APU_DMC_DMA_STATS_EN
   ,
   output logic [15:0]           oStall_count,
   output logic [7:0]            oAbort_count
`endif
);

   localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(STALL_CYCLES);
   localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(1);

   dma_state_t              state_reg, state_next;
   logic [STALL_W-1:0]      stall_cnt_reg, stall_cnt_next;
   logic [DMA_ADDR_W-1:0]   addr_reg, addr_next;
   logic [DMA_DATA_W-1:0]   data_reg, data_next;
   logic                    halt_reg, rd_reg, ack_reg;
   logic [DMA_ADDR_W-1:0]   mem_addr_reg;

   // Next-state logic: request latch, halt handshake, stall countdown, read.
   always_comb begin
      state_next     = state_reg;
      stall_cnt_next = stall_cnt_reg;
      addr_next      = addr_reg;
      data_next      = data_reg;
      case (state_reg)
         S_IDLE: begin
            if (iDMA_req) begin
               addr_next  = iDMA_addr;
               state_next = S_HALT;
            end
         end
         S_HALT: begin
            if (!iDMA_req) begin
               state_next = S_IDLE;
            end else if (iCPU_rdy) begin
               stall_cnt_next = STALL_LOAD;
               state_next     = (STALL_CYCLES == 0) ? S_READ : S_STALL;
            end
         end
         S_STALL: begin
            // The halt is already owned here, so iCPU_rdy no longer matters.
            if (!iDMA_req) begin
               stall_cnt_next = '0;
               state_next     = S_IDLE;
            end else begin
               stall_cnt_next = stall_cnt_reg - STALL_LAST;
               if (stall_cnt_reg == STALL_LAST) begin
                  state_next = S_READ;
               end
            end
         end
         S_READ: begin
            // Once issued, the read always completes and is acknowledged.
            if (iMem_valid) begin
               data_next  = iMem_data;
               state_next = S_ACK;
            end
         end
         S_ACK: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // State, capture and registered outputs decoded from the upcoming state.
   always_ff @(posedge iClk) begin
      if (iReset) begin
         state_reg     <= S_IDLE;
         stall_cnt_reg <= '0;
         addr_reg      <= '0;
         data_reg      <= '0;
         halt_reg      <= 1'b0;
         rd_reg        <= 1'b0;
         ack_reg       <= 1'b0;
         mem_addr_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         stall_cnt_reg <= stall_cnt_next;
         addr_reg      <= addr_next;
         data_reg      <= data_next;
         halt_reg      <= owns_bus(state_next);
         rd_reg        <= (state_next == S_READ);
         ack_reg       <= (state_next == S_ACK);
         mem_addr_reg  <= (state_next == S_READ) ? addr_next : '0;
      end
   end

   assign oDMA_ack  = ack_reg;
   assign oDMA_data = data_reg;
   assign oCPU_halt = halt_reg;
   assign oMem_rd   = rd_reg;
   assign oMem_addr = mem_addr_reg;

`ifdef APU_DMC_DMA_STATS_EN
   logic [15:0] stall_count_reg;
   logic [7:0]  abort_count_reg;
   logic        abort_evt;

   // An abort is a dropped request while still waiting in HALT or STALL.
   assign abort_evt = ((state_reg == S_HALT) || (state_reg == S_STALL)) && !iDMA_req;

   // Saturating halt-cycle counter and wrapping abort counter.
   always_ff @(posedge iClk) begin
      if (iReset) begin
         stall_count_reg <= '0;
         abort_count_reg <= '0;
      end else begin
         if (halt_reg && (stall_count_reg != 16'hFFFF)) begin
            stall_count_reg <= stall_count_reg + 16'd1;
         end
         if (abort_evt) begin
            abort_count_reg <= abort_count_reg + 8'd1;
         end
      end
   end

   assign oStall_count = stall_count_reg;
   assign oAbort_count = abort_count_reg;
`endif

endmodule

// File: tb/tb_apu_dmc_dma_responder.sv
// Self-checking bench for apu_dmc_dma_responder. Expected outputs come from a
// timeline model built from the phase lengths (halt wait, stall, read wait),
// compared every cycle, plus literal expectations for each scenario.
module tb_apu_dmc_dma_responder;

   localparam int S = 3;

   logic        iClk = 1'b0;
   logic        iReset, iDMA_req, iCPU_rdy, iMem_valid;
   logic [15:0] iDMA_addr;
   logic [7:0]  iMem_data;
   logic        oDMA_ack, oCPU_halt, oMem_rd;
   logic [7:0]  oDMA_data;
   logic [15:0] oMem_addr;
`ifdef APU_DMC_DMA_STATS_EN
   logic [15:0] oStall_count;
   logic [7:0]  oAbort_count;
`endif

   always #5 iClk = ~iClk;

   apu_dmc_dma_responder #(.STALL_CYCLES(S), .STALL_W(2)) dut (
      .iClk(iClk), .iReset(iReset),
      .iDMA_req(iDMA_req), .iDMA_addr(iDMA_addr),
      .oDMA_ack(oDMA_ack), .oDMA_data(oDMA_data),
      .oCPU_halt(oCPU_halt), .iCPU_rdy(iCPU_rdy),
      .oMem_rd(oMem_rd), .oMem_addr(oMem_addr),
      .iMem_data(iMem_data), .iMem_valid(iMem_valid)
`ifdef APU_DMC_DMA_STATS_EN
      , .oStall_count(oStall_count), .oAbort_count(oAbort_count)
`endif
   );

   // Model expectations (written by the stimulus process only)
   logic        e_ack, e_halt, e_rd;
   logic [7:0]  e_data;
   logic [15:0] e_maddr;
   int          e_stall, e_abort;
   logic        prev_halt, prev_abort, prev_rst;
   bit          check_en;
   int          cur_c;
   string       lit_name[64];
   int          lit_got[64], lit_exp[64];
   int          lit_n;
   int          r_ack_n, r_halt_n, r_rd_n, r_ack_c;

   // Written by the compare process only
   int checks = 0, failures = 0;
   int tot_ack = 0, tot_halt = 0, tot_rd = 0, last_ack_c = -1;
   int lit_done = 0;

   task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cur_c);
      end
   endtask

   // Single compare process: per-cycle model check plus queued literal checks.
   always @(negedge iClk) begin
      if (check_en) begin
         cmp("ack", 32'(oDMA_ack), 32'(e_ack));
         cmp("data", 32'(oDMA_data), 32'(e_data));
         cmp("halt", 32'(oCPU_halt), 32'(e_halt));
         cmp("mem_rd", 32'(oMem_rd), 32'(e_rd));
         cmp("mem_addr", 32'(oMem_addr), 32'(e_maddr));
`ifdef APU_DMC_DMA_STATS_EN
         cmp("stall_count", 32'(oStall_count), 32'(e_stall));
         cmp("abort_count", 32'(oAbort_count), 32'(e_abort % 256));
`endif
         if (oDMA_ack === 1'b1) begin
            tot_ack++;
            last_ack_c = cur_c;
         end
         if (oCPU_halt === 1'b1) tot_halt++;
         if (oMem_rd === 1'b1) tot_rd++;
      end
      while (lit_done < lit_n) begin
         cmp(lit_name[lit_done], 32'(lit_got[lit_done]), 32'(lit_exp[lit_done]));
         lit_done++;
      end
   end

   task automatic lit(input string nm, input int got, input int exp);
      lit_name[lit_n] = nm;
      lit_got[lit_n]  = got;
      lit_exp[lit_n]  = exp;
      lit_n++;
   endtask

   // Advance one cycle and fold the previous cycle into the counter model.
   task automatic next_cycle();
      @(posedge iClk);
      #1;
      if (prev_rst) begin
         e_stall = 0;
         e_abort = 0;
         e_data  = 8'h00;
      end else begin
         if (prev_halt && e_stall != 16'hFFFF) e_stall++;
         if (prev_abort) e_abort++;
      end
      prev_halt  = 1'b0;
      prev_abort = 1'b0;
      prev_rst   = 1'b0;
   endtask

   task automatic idle_cycles(input int n, input bit rst);
      for (int i = 0; i < n; i++) begin
         next_cycle();
         cur_c      = -1;
         iReset     = rst;
         iDMA_req   = 1'b0;
         iCPU_rdy   = 1'b0;
         iMem_valid = 1'b0;
         e_halt = 1'b0; e_rd = 1'b0; e_maddr = 16'h0; e_ack = 1'b0;
         prev_rst = rst;
      end
   endtask

   // One fetch: D = cycles with iCPU_rdy low after halt, M = read cycles until
   // valid, A = cycle where req is dropped (abort), R = cycle with iReset.
   // Timeline from req sampled in cycle 0: HALT 1..1+D, STALL next S cycles,
   // READ next M cycles, ACK at 2+D+S+M.
   task automatic run_fetch(input logic [15:0] addr, input logic [7:0] data,
                            input int D, input int M, input int A,
                            input bit drop_rd, input int R);
      int  k, last, b_ack, b_halt, b_rd, ph;
      bit  dead;
      k = 2 + D + S + M;
      last = k;
      if (A >= 0) last = A + 1;
      if (R >= 0) last = R + 1;
      b_ack = tot_ack; b_halt = tot_halt; b_rd = tot_rd;
      for (int c = 0; c <= last; c++) begin
         next_cycle();
         cur_c      = c;
         dead       = (A >= 0 && c > A) || (R >= 0 && c > R);
         iReset     = (R >= 0 && c == R);
         iDMA_req   = !dead && !(A >= 0 && c >= A) && !(drop_rd && c >= 2 + D + S);
         iDMA_addr  = (c == 0) ? addr : 16'($urandom);
         iCPU_rdy   = (D == 0) || (c >= 1 + D);
         iMem_valid = (M == 1) || (c == 1 + D + S + M);
         iMem_data  = iMem_valid ? data : ~data;
         if (dead || c == 0)        ph = 0;
         else if (c <= 1 + D)       ph = 1;
         else if (c <= 1 + D + S)   ph = 2;
         else if (c <= 1 + D + S + M) ph = 3;
         else                       ph = 4;
         e_halt  = (ph >= 1 && ph <= 3);
         e_rd    = (ph == 3);
         e_maddr = (ph == 3) ? addr : 16'h0;
         e_ack   = (ph == 4);
         if (ph == 4) e_data = data;
         prev_halt  = e_halt;
         prev_abort = (A >= 0 && c == A);
         prev_rst   = iReset;
      end
      @(negedge iClk);
      #1;
      r_ack_n  = tot_ack - b_ack;
      r_halt_n = tot_halt - b_halt;
      r_rd_n   = tot_rd - b_rd;
      r_ack_c  = (r_ack_n > 0) ? last_ack_c : -1;
      $display("fetch addr=%h data=%h acks=%0d ack_cycle=%0d halt_cycles=%0d rd_cycles=%0d",
               addr, data, r_ack_n, r_ack_c, r_halt_n, r_rd_n);
   endtask

   int b2b_base;

   initial begin
      iReset = 1'b1; iDMA_req = 1'b0; iDMA_addr = 16'h0;
      iCPU_rdy = 1'b0; iMem_valid = 1'b0; iMem_data = 8'h0;
      e_ack = 1'b0; e_halt = 1'b0; e_rd = 1'b0; e_data = 8'h0; e_maddr = 16'h0;
      e_stall = 0; e_abort = 0;
      prev_halt = 1'b0; prev_abort = 1'b0; prev_rst = 1'b0;
      check_en = 1'b0; cur_c = -1; lit_n = 0;
      r_ack_n = 0; r_halt_n = 0; r_rd_n = 0; r_ack_c = -1;

      next_cycle();
      iReset = 1'b1;
      prev_rst = 1'b1;
      next_cycle();
      iReset = 1'b0;
      check_en = 1'b1;

      // Basic fetch with rdy/valid tied high
      run_fetch(16'hC040, 8'hA5, 0, 1, -1, 1'b0, -1);
      lit("basic_ack_cycle", r_ack_c, 6);
      lit("basic_halt_cycles", r_halt_n, 5);
      lit("basic_acks", r_ack_n, 1);
      idle_cycles(2, 1'b0);

      // Slow CPU: rdy low for 4 cycles after halt
      run_fetch(16'h1234, 8'h5A, 4, 1, -1, 1'b0, -1);
      lit("slowcpu_ack_cycle", r_ack_c, 10);
      lit("slowcpu_halt_cycles", r_halt_n, 9);
      lit("slowcpu_acks", r_ack_n, 1);
      idle_cycles(1, 1'b0);

      // Slow memory: valid on the third read cycle
      run_fetch(16'h2222, 8'h3C, 0, 3, -1, 1'b0, -1);
      lit("slowmem_rd_cycles", r_rd_n, 3);
      lit("slowmem_acks", r_ack_n, 1);
      lit("slowmem_ack_cycle", r_ack_c, 8);
      idle_cycles(1, 1'b0);

      // Abort in the second STALL cycle
      run_fetch(16'h4444, 8'h77, 0, 1, 3, 1'b0, -1);
      lit("abort_acks", r_ack_n, 0);
      lit("abort_rd_cycles", r_rd_n, 0);
      lit("abort_halt_cycles", r_halt_n, 3);
      idle_cycles(1, 1'b0);

      // Request dropped during READ still gets its ack
      run_fetch(16'h5555, 8'h66, 0, 1, -1, 1'b1, -1);
      lit("dropread_acks", r_ack_n, 1);
      lit("dropread_ack_cycle", r_ack_c, 6);
      idle_cycles(1, 1'b0);

      // Reset in the middle of a slow read, then a normal fetch
      run_fetch(16'h6666, 8'h99, 0, 3, -1, 1'b0, 6);
      lit("rstread_acks", r_ack_n, 0);
      lit("rstread_rd_cycles", r_rd_n, 2);
      lit("rstread_halt_cycles", r_halt_n, 6);
      idle_cycles(1, 1'b0);
      run_fetch(16'h7777, 8'hE1, 0, 1, -1, 1'b0, -1);
      lit("after_rst_acks", r_ack_n, 1);
      lit("after_rst_ack_cycle", r_ack_c, 6);

      // Back-to-back fetches after a fresh reset, new request in the cycle after ack
      idle_cycles(1, 1'b1);
      b2b_base = tot_ack;
      run_fetch(16'hFFFE, 8'h11, 0, 1, -1, 1'b0, -1);
      run_fetch(16'hFFFF, 8'h22, 0, 1, -1, 1'b0, -1);
      run_fetch(16'h8000, 8'h33, 0, 1, -1, 1'b0, -1);
      lit("b2b_acks", tot_ack - b2b_base, 3);
      lit("b2b_last_data", int'(oDMA_data), 8'h33);
`ifdef APU_DMC_DMA_STATS_EN
      lit("b2b_stall_count", int'(oStall_count), 15);
      lit("b2b_abort_count", int'(oAbort_count), 0);
`endif

      idle_cycles(2, 1'b0);
      @(negedge iClk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
